// File: rtl/route_compute.sv
// XY route computation stage: per input port a 2-deep flit FIFO plus a packet
// FSM that tags the head flit with its route code or drops malformed flits.

module route_compute_port #(
    parameter logic [3:0] CUR_X = 4'd0,
    parameter logic [3:0] CUR_Y = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] din_i,
    input  logic        din_valid_i,
    output logic        din_ready_o,
    output logic [39:0] dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic [1:0]  route_o,
    output logic        err_o,
    output logic        state_o
);
    // Handshake: a flit moves on a side only in a cycle where both valid and
    // ready are 1; valid never waits on ready, and held outputs stay stable.
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_PACKET = 1'b1;

    localparam logic [1:0] T_HEADER = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b11;

    logic [39:0] mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [0:0]  state_q, state_d;
    logic [1:0]  route_q, route_d;
    // Holds din_ready low until the first edge after reset is released.
    logic        rdy_en_q;

    logic [39:0] head;
    logic [1:0]  head_type;
    logic        not_empty;
    logic        head_starts;
    logic        drop;
    logic        valid;
    logic        push;
    logic        pop;
    logic [1:0]  xy_code;

    assign head        = mem_q[rd_ptr_q];
    assign head_type   = head[39:38];
    assign not_empty   = (count_q != 2'd0);
    assign head_starts = ~head_type[1];
    assign drop        = not_empty & ((state_q == S_IDLE) ? ~head_starts : head_starts);
    assign valid       = not_empty & ~drop;

    assign din_ready_o = rdy_en_q & (count_q != 2'd2);
    assign push        = din_valid_i & din_ready_o;
    assign pop         = (valid & dout_ready_i) | drop;

    always_comb begin
        xy_code = 2'b11;
        if (head[37:34] != CUR_X) begin
            xy_code = 2'b01;
        end else if (head[33:30] != CUR_Y) begin
            xy_code = 2'b10;
        end
    end

    assign dout_o       = head;
    assign dout_valid_o = valid;
    assign route_o      = valid ? ((state_q == S_PACKET) ? route_q : xy_code) : 2'b00;
    assign err_o        = drop;
    assign state_o      = state_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Dropped flits never change the packet state.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (pop && !drop) begin
            if (state_q == S_IDLE && head_type == T_HEADER) begin
                state_d = S_PACKET;
                route_d = xy_code;
            end else if (state_q == S_PACKET && head_type == T_TAIL) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            state_q  <= S_IDLE;
            route_q  <= 2'b00;
            rdy_en_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            route_q  <= route_d;
            rdy_en_q <= 1'b1;
        end
    end
endmodule

module route_compute #(
    parameter logic [3:0] CUR_X = 4'd0,
    parameter logic [3:0] CUR_Y = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] din_x,
    input  logic        din_valid_x,
    output logic        din_ready_x,
    output logic [39:0] dout_x,
    output logic        dout_valid_x,
    input  logic        dout_ready_x,
    output logic [1:0]  router_algorithm_out_x,
    output logic        err_x,
    input  logic [39:0] din_y,
    input  logic        din_valid_y,
    output logic        din_ready_y,
    output logic [39:0] dout_y,
    output logic        dout_valid_y,
    input  logic        dout_ready_y,
    output logic [1:0]  router_algorithm_out_y,
    output logic        err_y,
    input  logic [39:0] din_local,
    input  logic        din_valid_local,
    output logic        din_ready_local,
    output logic [39:0] dout_local,
    output logic        dout_valid_local,
    input  logic        dout_ready_local,
    output logic [1:0]  router_algorithm_out_local,
    output logic        err_local,
    output logic [2:0]  dbg_state_o
);
    // dbg_state_o = {local, y, x}; 1 means the port is inside a packet.
    route_compute_port #(.CUR_X(CUR_X), .CUR_Y(CUR_Y)) u_port_x (
        .clk(clk), .rst(rst),
        .din_i(din_x), .din_valid_i(din_valid_x), .din_ready_o(din_ready_x),
        .dout_o(dout_x), .dout_valid_o(dout_valid_x), .dout_ready_i(dout_ready_x),
        .route_o(router_algorithm_out_x), .err_o(err_x), .state_o(dbg_state_o[0])
    );

    route_compute_port #(.CUR_X(CUR_X), .CUR_Y(CUR_Y)) u_port_y (
        .clk(clk), .rst(rst),
        .din_i(din_y), .din_valid_i(din_valid_y), .din_ready_o(din_ready_y),
        .dout_o(dout_y), .dout_valid_o(dout_valid_y), .dout_ready_i(dout_ready_y),
        .route_o(router_algorithm_out_y), .err_o(err_y), .state_o(dbg_state_o[1])
    );

    route_compute_port #(.CUR_X(CUR_X), .CUR_Y(CUR_Y)) u_port_local (
        .clk(clk), .rst(rst),
        .din_i(din_local), .din_valid_i(din_valid_local), .din_ready_o(din_ready_local),
        .dout_o(dout_local), .dout_valid_o(dout_valid_local), .dout_ready_i(dout_ready_local),
        .route_o(router_algorithm_out_local), .err_o(err_local), .state_o(dbg_state_o[2])
    );
endmodule

// File: tb/tb_route_compute.sv
// Bench for route_compute: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based port model.

module tb_route_compute;
    localparam logic [3:0] CX = 4'd0;
    localparam logic [3:0] CY = 4'd0;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // port index 0 = x, 1 = y, 2 = local
    logic [2:0][39:0] din;
    logic [2:0][39:0] dout;
    logic [2:0][1:0]  code;
    logic [2:0]       din_valid = '0;
    logic [2:0]       dout_ready = '0;
    logic [2:0]       din_ready, dout_valid, err, dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    string pn[3] = '{"x", "y", "local"};

    route_compute #(.CUR_X(CX), .CUR_Y(CY)) dut (
        .clk(clk), .rst(rst),
        .din_x(din[0]), .din_valid_x(din_valid[0]), .din_ready_x(din_ready[0]),
        .dout_x(dout[0]), .dout_valid_x(dout_valid[0]), .dout_ready_x(dout_ready[0]),
        .router_algorithm_out_x(code[0]), .err_x(err[0]),
        .din_y(din[1]), .din_valid_y(din_valid[1]), .din_ready_y(din_ready[1]),
        .dout_y(dout[1]), .dout_valid_y(dout_valid[1]), .dout_ready_y(dout_ready[1]),
        .router_algorithm_out_y(code[1]), .err_y(err[1]),
        .din_local(din[2]), .din_valid_local(din_valid[2]), .din_ready_local(din_ready[2]),
        .dout_local(dout[2]), .dout_valid_local(dout_valid[2]), .dout_ready_local(dout_ready[2]),
        .router_algorithm_out_local(code[2]), .err_local(err[2]),
        .dbg_state_o(dbg_state)
    );

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input logic [29:0] pl);
        return {t, x, y, pl};
    endfunction

    function automatic logic [1:0] xy_route(input logic [39:0] f);
        if (f[37:34] != CX) return 2'b01;
        if (f[33:30] != CY) return 2'b10;
        return 2'b11;
    endfunction

    // scoreboard: per-port flit queue plus packet state
    logic [39:0] exp_q[3][$];
    logic        in_pkt[3];
    logic [1:0]  route_m[3];
    logic        rdy_en_m = 1'b0;

    initial begin
        for (int p = 0; p < 3; p++) begin
            in_pkt[p]  = 1'b0;
            route_m[p] = 2'b00;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("rst_ready_%s", pn[p]), din_ready[p], 0);
                chk($sformatf("rst_valid_%s", pn[p]), dout_valid[p], 0);
                chk($sformatf("rst_dout_%s", pn[p]), dout[p], 0);
                chk($sformatf("rst_code_%s", pn[p]), code[p], 0);
                chk($sformatf("rst_err_%s", pn[p]), err[p], 0);
                exp_q[p].delete();
                in_pkt[p]  = 1'b0;
                route_m[p] = 2'b00;
            end
            rdy_en_m = 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                logic        has, starts, e_drop, e_valid, e_ready, do_push, do_pop;
                logic [39:0] h;
                logic [1:0]  e_code;
                has     = exp_q[p].size() > 0;
                h       = has ? exp_q[p][0] : 40'd0;
                starts  = (h[39:38] == 2'b00) || (h[39:38] == 2'b01);
                e_drop  = has && (in_pkt[p] ? starts : !starts);
                e_valid = has && !e_drop;
                e_code  = !e_valid ? 2'b00 : (in_pkt[p] ? route_m[p] : xy_route(h));
                e_ready = rdy_en_m && exp_q[p].size() < 2;
                chk($sformatf("ready_%s", pn[p]), din_ready[p], e_ready);
                chk($sformatf("valid_%s", pn[p]), dout_valid[p], e_valid);
                chk($sformatf("code_%s", pn[p]), code[p], e_code);
                chk($sformatf("err_%s", pn[p]), err[p], e_drop);
                chk($sformatf("state_%s", pn[p]), dbg_state[p], in_pkt[p]);
                if (e_valid) chk($sformatf("dout_%s", pn[p]), dout[p], h);
                do_push = din_valid[p] && e_ready;
                do_pop  = (e_valid && dout_ready[p]) || e_drop;
                if (do_pop) begin
                    void'(exp_q[p].pop_front());
                    if (!e_drop) begin
                        if (!in_pkt[p] && h[39:38] == 2'b01) begin
                            in_pkt[p]  = 1'b1;
                            route_m[p] = e_code;
                        end else if (in_pkt[p] && h[39:38] == 2'b11) begin
                            in_pkt[p] = 1'b0;
                        end
                    end
                end
                if (do_push) exp_q[p].push_back(din[p]);
            end
            rdy_en_m = 1'b1;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [39:0] f);
        logic done;
        done = 1'b0;
        din[p] = f;
        din_valid[p] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = din_ready[p];
            tick();
        end
        din_valid[p] = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout_%s: got ready 0 expected ready 1 within 50 cycles", pn[p]);
        end
    endtask

    function automatic logic [39:0] rand_flit();
        return mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 1)),
                  4'($urandom_range(0, 1)), 30'($urandom));
    endfunction

    initial begin
        logic [39:0] f1, g0, g1, g2;
        logic [39:0] got[$];
        logic        rd;
        int          seen;
        din = '0;
        #200000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] f1, g0, g1, g2;
        logic [39:0] got[$];
        logic        rd;
        int          seen;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lit_ready_x", din_ready[0], 0);
        chk("rst_lit_dout_x", dout[0], 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_first_edge", din_ready[0], 0);
        tick();
        @(negedge clk);
        chk("ready_after_first_edge", din_ready[0], 1);

        // single flit on x, dest (3,0)
        tick();
        f1 = mk(2'b00, 4'd3, 4'd0, 30'h1234);
        din[0] = f1;
        din_valid[0] = 1'b1;
        @(negedge clk);
        chk("x_not_early", dout_valid[0], 0);
        tick();
        din_valid[0] = 1'b0;
        @(negedge clk);
        chk("x_single_valid", dout_valid[0], 1);
        chk("x_single_code", code[0], 2'b01);
        chk("x_single_dout", dout[0], f1);
        tick();
        dout_ready[0] = 1'b1;
        tick();
        dout_ready[0] = 1'b0;
        @(negedge clk);
        chk("x_single_drained", dout_valid[0], 0);
        chk("x_single_idle", dbg_state[0], 0);

        // header, 2 body, tail on y with dest (0,2)
        tick();
        dout_ready[1] = 1'b1;
        seen = 0;
        fork
            begin
                send(1, mk(2'b01, 4'd0, 4'd2, 30'h11));
                send(1, mk(2'b10, 4'd0, 4'd0, 30'h22));
                send(1, mk(2'b10, 4'd0, 4'd0, 30'h33));
                send(1, mk(2'b11, 4'd0, 4'd0, 30'h44));
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    if (dout_valid[1]) begin
                        chk("y_pkt_code", code[1], 2'b10);
                        seen++;
                    end
                end
            end
        join
        chk("y_pkt_flits", seen, 4);
        chk("y_pkt_idle", dbg_state[1], 0);
        tick();
        dout_ready[1] = 1'b0;

        // stray body flit on local while idle
        send(2, mk(2'b10, 4'd1, 4'd1, 30'h55));
        @(negedge clk);
        chk("local_err_pulse", err[2], 1);
        chk("local_drop_valid", dout_valid[2], 0);
        chk("local_drop_code", code[2], 2'b00);
        @(negedge clk);
        chk("local_err_end", err[2], 0);
        chk("local_drop_gone", dout_valid[2], 0);

        // back-pressure on x with three flits
        tick();
        g0 = mk(2'b00, 4'd1, 4'd1, 30'hA0);
        g1 = mk(2'b00, 4'd0, 4'd2, 30'hA1);
        g2 = mk(2'b00, 4'd2, 4'd0, 30'hA2);
        din[0] = g0;
        din_valid[0] = 1'b1;
        @(negedge clk);
        chk("x_bp_ready0", din_ready[0], 1);
        tick();
        din[0] = g1;
        @(negedge clk);
        chk("x_bp_ready1", din_ready[0], 1);
        chk("x_bp_head1", dout[0], g0);
        tick();
        din[0] = g2;
        @(negedge clk);
        chk("x_bp_full", din_ready[0], 0);
        chk("x_bp_head2", dout[0], g0);
        chk("x_bp_code", code[0], 2'b01);
        tick();
        @(negedge clk);
        chk("x_bp_still_full", din_ready[0], 0);
        chk("x_bp_stable", dout[0], g0);
        tick();
        dout_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dout_valid[0]) got.push_back(dout[0]);
            rd = din_ready[0];
            tick();
            if (rd) din_valid[0] = 1'b0;
        end
        dout_ready[0] = 1'b0;
        chk("x_drain_count", got.size(), 3);
        if (got.size() >= 3) begin
            chk("x_drain_0", got[0], g0);
            chk("x_drain_1", got[1], g1);
            chk("x_drain_2", got[2], g2);
        end

        // reset in the middle of a packet on y
        send(1, mk(2'b01, 4'd0, 4'd1, 30'h66));
        @(negedge clk);
        chk("y_hdr_valid", dout_valid[1], 1);
        tick();
        rst = 1'b1;
        #1;
        chk("y_rst_valid", dout_valid[1], 0);
        chk("y_rst_ready", din_ready[1], 0);
        chk("y_rst_dout", dout[1], 0);
        chk("y_rst_code", code[1], 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("y_rel_ready", din_ready[1], 0);
        tick();
        send(1, mk(2'b10, 4'd0, 4'd1, 30'h77));
        @(negedge clk);
        chk("y_post_rst_err", err[1], 1);
        chk("y_post_rst_valid", dout_valid[1], 0);

        // all three ports to the local node at once
        tick();
        for (int p = 0; p < 3; p++) begin
            din[p] = mk(2'b00, CX, CY, 30'(p + 100));
            din_valid[p] = 1'b1;
        end
        @(negedge clk);
        for (int p = 0; p < 3; p++) chk($sformatf("all_ready_%s", pn[p]), din_ready[p], 1);
        tick();
        din_valid = '0;
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("all_valid_%s", pn[p]), dout_valid[p], 1);
            chk($sformatf("all_code_%s", pn[p]), code[p], 2'b11);
        end
        tick();
        dout_ready = '1;
        tick();
        dout_ready = '0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            for (int p = 0; p < 3; p++) begin
                din_valid[p]  = ($urandom_range(0, 9) < 6);
                din[p]        = rand_flit();
                dout_ready[p] = ($urandom_range(0, 9) < 7);
            end
        end
        tick();
        rst = 1'b0;
        din_valid = '0;
        dout_ready = '1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
